sdc_dma_wb_arbiter: RTL and testbench

- Two-master, one-slave Wishbone arbiter.
- Shares one slave between two requesters:
  - the SD controller DMA master (m0);
  - a host/bench master (m1) that pre-loads or checks buffer contents.
- Typical slaves: the DMA RAM or the FIFO path.
- Grant is round-robin at bus-cycle (cyc) granularity.
- A bus-hang watchdog returns err to the owner when the slave never acks.

---
 rtl/sdc_dma_wb_arbiter_if.sv | 30 +++
 rtl/sdc_dma_wb_arbiter.sv | 178 +++++++++++++++++
 tb/tb_sdc_dma_wb_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdc_dma_wb_arbiter_if.sv
// Wishbone B4 classic/registered-feedback bus bundle shared by the arbiter's
// master-facing and slave-facing ports.
interface sdc_dma_wb_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic [AW-1:0]   adr;
  logic [DW-1:0]   dat_w;
  logic [DW/8-1:0] sel;
  logic            we;
  logic            cyc;
  logic            stb;
  logic [2:0]      cti;
  logic [1:0]      bte;
  logic [DW-1:0]   dat_r;
  logic            ack;
  logic            err;

  // The side that starts bus cycles.
  modport master (
    output adr, dat_w, sel, we, cyc, stb, cti, bte,
    input  dat_r, ack, err
  );

  // The side that answers bus cycles.
  modport slave (
    input  adr, dat_w, sel, we, cyc, stb, cti, bte,
    output dat_r, ack, err
  );
endinterface

// File: rtl/sdc_dma_wb_arbiter.sv
// Two-master, one-slave Wishbone arbiter for the SD controller DMA path.
// m0 is the DMA master, m1 the host master. Ownership is granted round-robin
// per bus cycle (cyc), held for the whole cycle, and a watchdog converts a
// slave that never answers into a one-cycle err to the current owner.
module sdc_dma_wb_arbiter #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  sdc_dma_wb_arbiter_if.slave   m0,
  sdc_dma_wb_arbiter_if.slave   m1,
  sdc_dma_wb_arbiter_if.master  s,
  output logic [1:0]            grant_o,
  output logic [15:0]           timeout_cnt_o
);

  // Watchdog width holds 0..TIMEOUT; a disabled watchdog keeps a 1-bit stub.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WD_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            last_q, last_d;     // 0: m0 owned last, 1: m1 owned last
  logic [CW-1:0]   wd_q, wd_d;
  logic [15:0]     tocnt_q, tocnt_d;

  logic            own_stb;
  logic            wd_wait;
  logic            wd_expire;

  // Owner strobe, stall detection and watchdog expiry for the current owner.
  always_comb begin
    own_stb   = (state_q == ST_OWN1) ? m1.stb : m0.stb;
    wd_wait   = ((state_q == ST_OWN0) || (state_q == ST_OWN1)) &&
                own_stb && !s.ack && !s.err;
    wd_expire = (TIMEOUT != 0) && wd_wait && (wd_q == WD_LAST);
  end

  // Next-state: arbitration, release hand-over and watchdog bookkeeping.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    tocnt_d = tocnt_q;
    wd_d    = '0;

    case (state_q)
      ST_OWN0: begin
        if (!m0.cyc) begin
          last_d  = 1'b0;
          state_d = m1.cyc ? ST_OWN1 : ST_IDLE;
        end else if (wd_expire) begin
          last_d  = 1'b0;
          state_d = ST_ERR;
        end
      end
      ST_OWN1: begin
        if (!m1.cyc) begin
          last_d  = 1'b1;
          state_d = m0.cyc ? ST_OWN0 : ST_IDLE;
        end else if (wd_expire) begin
          last_d  = 1'b1;
          state_d = ST_ERR;
        end
      end
      default: begin
        // IDLE and the single ERR cycle both re-arbitrate from scratch;
        // on a tie the master that did not own the bus last wins.
        if (m0.cyc && m1.cyc) begin
          state_d = last_q ? ST_OWN0 : ST_OWN1;
        end else if (m0.cyc) begin
          state_d = ST_OWN0;
        end else if (m1.cyc) begin
          state_d = ST_OWN1;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase

    // Stall counter keeps running only while the same owner keeps waiting.
    if ((TIMEOUT != 0) && wd_wait && (state_d == state_q)) begin
      wd_d = wd_q + 1'b1;
    end

    if ((state_d == ST_ERR) && (state_q != ST_ERR) && (tocnt_q != 16'hFFFF)) begin
      tocnt_d = tocnt_q + 16'd1;
    end
  end

  // State, round-robin pointer, watchdog and event counter registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      wd_q    <= '0;
      tocnt_q <= 16'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      tocnt_q <= tocnt_d;
    end
  end

  // Bus steering: owner's request to the slave, slave's response to the owner.
  always_comb begin
    s.adr   = m0.adr;
    s.dat_w = m0.dat_w;
    s.sel   = m0.sel;
    s.we    = m0.we;
    s.cti   = m0.cti;
    s.bte   = m0.bte;
    s.cyc   = 1'b0;
    s.stb   = 1'b0;
    m0.ack  = 1'b0;
    m0.err  = 1'b0;
    m1.ack  = 1'b0;
    m1.err  = 1'b0;
    grant_o = 2'b00;

    if (state_q == ST_OWN1) begin
      s.adr   = m1.adr;
      s.dat_w = m1.dat_w;
      s.sel   = m1.sel;
      s.we    = m1.we;
      s.cti   = m1.cti;
      s.bte   = m1.bte;
    end

    case (state_q)
      ST_OWN0: begin
        s.cyc   = m0.cyc;
        s.stb   = m0.stb;
        m0.ack  = s.ack;
        m0.err  = s.err;
        grant_o = 2'b01;
      end
      ST_OWN1: begin
        s.cyc   = m1.cyc;
        s.stb   = m1.stb;
        m1.ack  = s.ack;
        m1.err  = s.err;
        grant_o = 2'b10;
      end
      ST_ERR: begin
        // Slave side stays quiet; the timed-out owner sees err for one cycle.
        m0.err  = !last_q;
        m1.err  = last_q;
        grant_o = last_q ? 2'b10 : 2'b01;
      end
      default: ;
    endcase

    // A reset being sampled drops the slave request and blocks any response.
    if (wb_rst_i) begin
      s.cyc  = 1'b0;
      s.stb  = 1'b0;
      m0.ack = 1'b0;
      m0.err = 1'b0;
      m1.ack = 1'b0;
      m1.err = 1'b0;
    end
  end

  // Read data is broadcast; only the owner's ack qualifies it.
  assign m0.dat_r      = s.dat_r;
  assign m1.dat_r      = s.dat_r;
  assign timeout_cnt_o = tocnt_q;

endmodule

// File: tb/tb_sdc_dma_wb_arbiter.sv
// Self-checking bench for sdc_dma_wb_arbiter: directed scenarios plus a
// randomized run against a cycle-level behavioural model of the arbiter.
module tb_sdc_dma_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  grant;
  logic [15:0] tocnt;

  always #5 clk = ~clk;

  sdc_dma_wb_arbiter_if #(.DW(DW), .AW(AW)) m0_if ();
  sdc_dma_wb_arbiter_if #(.DW(DW), .AW(AW)) m1_if ();
  sdc_dma_wb_arbiter_if #(.DW(DW), .AW(AW)) s_if ();

  sdc_dma_wb_arbiter #(.DW(DW), .AW(AW), .TIMEOUT(TO)) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .m0            (m0_if),
    .m1            (m1_if),
    .s             (s_if),
    .grant_o       (grant),
    .timeout_cnt_o (tocnt)
  );

  int checks   = 0;
  int failures = 0;
  int exp_to   = 0;

  // {grant[1:0], s_cyc, s_stb, m0_ack, m1_ack, m0_err, m1_err}
  function automatic logic [7:0] obs();
    return {grant, s_if.cyc, s_if.stb, m0_if.ack, m1_if.ack, m0_if.err, m1_if.err};
  endfunction

  task automatic drive_m(input int i, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat, input logic [2:0] cti);
    if (i == 0) begin
      m0_if.cyc = cyc; m0_if.stb = stb; m0_if.we = we;
      m0_if.adr = adr; m0_if.dat_w = dat; m0_if.cti = cti;
      m0_if.sel = 4'hF; m0_if.bte = 2'b00;
    end else begin
      m1_if.cyc = cyc; m1_if.stb = stb; m1_if.we = we;
      m1_if.adr = adr; m1_if.dat_w = dat; m1_if.cti = cti;
      m1_if.sel = 4'hF; m1_if.bte = 2'b00;
    end
  endtask

  task automatic idle_inputs();
    drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    drive_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    s_if.ack = 1'b0; s_if.err = 1'b0; s_if.dat_r = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_to = 0;
  endtask

  task automatic settle();
    @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 3'b000);
    drive_m(1, 1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 3'b000);
    s_if.ack = 1'b1; s_if.err = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (obs() !== 8'h00) begin failures++; $display("FAIL reset_outputs: got %b expected %b", obs(), 8'h00); end
    checks++;
    if (tocnt !== 16'd0) begin failures++; $display("FAIL reset_tocnt: got %0d expected 0", tocnt); end
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (obs() !== 8'h00) begin failures++; $display("FAIL reset_idle: got %b expected %b", obs(), 8'h00); end
  endtask

  task automatic test_single();
    @(negedge clk);
    drive_m(0, 1'b1, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 3'b000);
    #1;
    checks++;
    if (obs() !== 8'b00_000000) begin failures++; $display("FAIL single_latency: got %b expected %b", obs(), 8'b00_000000); end
    @(negedge clk);
    #1;
    checks++;
    if (obs() !== 8'b01_110000) begin failures++; $display("FAIL single_grant: got %b expected %b", obs(), 8'b01_110000); end
    checks++;
    if ({s_if.adr, s_if.dat_w, s_if.sel, s_if.we} !== {32'h10, 32'hDEADBEEF, 4'hF, 1'b1}) begin
      failures++; $display("FAIL single_fwd: got %h %h %h %b expected 10 deadbeef f 1", s_if.adr, s_if.dat_w, s_if.sel, s_if.we);
    end
    @(negedge clk);
    s_if.ack = 1'b1; s_if.dat_r = 32'h12345678;
    #1;
    checks++;
    if (obs() !== 8'b01_111000) begin failures++; $display("FAIL single_ack: got %b expected %b", obs(), 8'b01_111000); end
    checks++;
    if (m0_if.dat_r !== 32'h12345678) begin failures++; $display("FAIL single_rdata: got %h expected 12345678", m0_if.dat_r); end
    @(negedge clk);
    s_if.ack = 1'b0;
    drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    #1;
    checks++;
    if (obs() !== 8'b01_000000) begin failures++; $display("FAIL single_drop: got %b expected %b", obs(), 8'b01_000000); end
    @(negedge clk);
    #1;
    checks++;
    if (obs() !== 8'h00) begin failures++; $display("FAIL single_idle: got %b expected %b", obs(), 8'h00); end
  endtask

  task automatic test_tie();
    do_reset();
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'hA0, 32'h0, 3'b000);
    drive_m(1, 1'b1, 1'b1, 1'b0, 32'hB0, 32'h0, 3'b000);
    @(negedge clk);
    #1;
    checks++;
    if (obs() !== 8'b01_110000 || s_if.adr !== 32'hA0) begin
      failures++; $display("FAIL tie_first: got %b adr %h expected %b adr a0", obs(), s_if.adr, 8'b01_110000);
    end
    @(negedge clk);
    drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    #1;
    checks++;
    if (obs() !== 8'b01_000000) begin failures++; $display("FAIL tie_release: got %b expected %b", obs(), 8'b01_000000); end
    @(negedge clk);
    #1;
    checks++;
    if (obs() !== 8'b10_110000 || s_if.adr !== 32'hB0) begin
      failures++; $display("FAIL tie_handover: got %b adr %h expected %b adr b0", obs(), s_if.adr, 8'b10_110000);
    end
    drive_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    @(negedge clk);
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'hA4, 32'h0, 3'b000);
    drive_m(1, 1'b1, 1'b1, 1'b0, 32'hB4, 32'h0, 3'b000);
    #1;
    checks++;
    if (obs() !== 8'h00) begin failures++; $display("FAIL tie_gap_idle: got %b expected %b", obs(), 8'h00); end
    @(negedge clk);
    #1;
    checks++;
    if (obs() !== 8'b01_110000) begin failures++; $display("FAIL tie_second: got %b expected %b", obs(), 8'b01_110000); end
    settle();
  endtask

  task automatic test_burst();
    logic [2:0] cti;
    @(negedge clk);
    drive_m(1, 1'b1, 1'b1, 1'b1, 32'h100, 32'hA0, 3'b010);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      if (b == 0) drive_m(0, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 3'b000);
      cti = (b == 3) ? 3'b111 : 3'b010;
      drive_m(1, 1'b1, 1'b1, 1'b1, 32'h100 + 32'(4 * b), 32'hA0 + 32'(b), cti);
      s_if.ack = 1'b1;
      #1;
      checks++;
      if (obs() !== 8'b10_110100 || s_if.cti !== cti || s_if.adr !== 32'h100 + 32'(4 * b)) begin
        failures++; $display("FAIL burst_beat%0d: got %b cti %b adr %h expected %b cti %b", b, obs(), s_if.cti, s_if.adr, 8'b10_110100, cti);
      end
    end
    @(negedge clk);
    s_if.ack = 1'b0;
    drive_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    #1;
    checks++;
    if (obs() !== 8'b10_000000) begin failures++; $display("FAIL burst_end: got %b expected %b", obs(), 8'b10_000000); end
    @(negedge clk);
    #1;
    checks++;
    if (obs() !== 8'b01_110000 || s_if.adr !== 32'h200) begin
      failures++; $display("FAIL burst_m0_after: got %b adr %h expected %b adr 200", obs(), s_if.adr, 8'b01_110000);
    end
    settle();
  endtask

  task automatic test_watchdog();
    do_reset();
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 3'b000);
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      if (k == 1) drive_m(1, 1'b1, 1'b1, 1'b0, 32'h80, 32'h0, 3'b000);
      #1;
      checks++;
      if (obs() !== 8'b01_110000) begin failures++; $display("FAIL wd_wait%0d: got %b expected %b", k, obs(), 8'b01_110000); end
    end
    @(negedge clk);
    #1;
    exp_to = 1;
    checks++;
    if (obs() !== 8'b01_000010) begin failures++; $display("FAIL wd_err: got %b expected %b", obs(), 8'b01_000010); end
    checks++;
    if (tocnt !== 16'(exp_to)) begin failures++; $display("FAIL wd_tocnt: got %0d expected %0d", tocnt, exp_to); end
    @(negedge clk);
    drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    #1;
    checks++;
    if (obs() !== 8'b10_110000 || s_if.adr !== 32'h80) begin
      failures++; $display("FAIL wd_m1_next: got %b adr %h expected %b adr 80", obs(), s_if.adr, 8'b10_110000);
    end
    settle();
  endtask

  task automatic test_slave_err();
    @(negedge clk);
    drive_m(1, 1'b1, 1'b1, 1'b0, 32'hC0, 32'h0, 3'b000);
    @(negedge clk);
    s_if.err = 1'b1;
    #1;
    checks++;
    if (obs() !== 8'b10_110001) begin failures++; $display("FAIL serr_pass: got %b expected %b", obs(), 8'b10_110001); end
    @(negedge clk);
    s_if.err = 1'b0;
    drive_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    @(negedge clk);
    #1;
    checks++;
    if (tocnt !== 16'(exp_to)) begin failures++; $display("FAIL serr_tocnt: got %0d expected %0d", tocnt, exp_to); end
    settle();
  endtask

  task automatic test_random();
    int owner, last, waitc, eowner, mto;
    bit inerr, dead, sa, se;
    bit c[2];
    bit st[2];
    logic [31:0] adr[2];
    logic [31:0] dat[2];
    logic [7:0] e;
    do_reset();
    owner = -1; last = 1; waitc = 0; eowner = 0; mto = 0; inerr = 0; dead = 0;
    c[0] = 0; c[1] = 0; st[0] = 0; st[1] = 0;
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      if (n % 32 == 0) dead = ($urandom % 3) == 0;
      for (int i = 0; i < 2; i++) begin
        if (c[i]) begin
          if ($urandom % 16 == 0) begin c[i] = 0; st[i] = 0; end
          else st[i] = ($urandom % 8) != 0;
        end else if ($urandom % 4 == 0) begin
          c[i] = 1; st[i] = 1;
        end
        adr[i] = $urandom; dat[i] = $urandom;
        drive_m(i, c[i], st[i], 1'($urandom), adr[i], dat[i], 3'($urandom));
      end
      sa = dead ? 1'b0 : 1'($urandom % 2);
      se = dead ? 1'b0 : (($urandom % 16) == 0);
      s_if.ack = sa; s_if.err = se; s_if.dat_r = $urandom;
      #1;
      // Expected bus view for the current cycle.
      if (inerr) e = {(eowner == 1) ? 2'b10 : 2'b01, 4'b0000, eowner == 0, eowner == 1};
      else if (owner == 0) e = {2'b01, c[0], st[0], sa, 1'b0, se, 1'b0};
      else if (owner == 1) e = {2'b10, c[1], st[1], 1'b0, sa, 1'b0, se};
      else e = 8'h00;
      checks++;
      if (obs() !== e) begin failures++; $display("FAIL rand_bus@%0d: got %b expected %b", n, obs(), e); end
      checks++;
      if (tocnt !== 16'(mto)) begin failures++; $display("FAIL rand_tocnt@%0d: got %0d expected %0d", n, tocnt, mto); end
      if (!inerr && owner >= 0) begin
        checks++;
        if (s_if.adr !== adr[owner] || s_if.dat_w !== dat[owner]) begin
          failures++; $display("FAIL rand_fwd@%0d: got %h %h expected %h %h", n, s_if.adr, s_if.dat_w, adr[owner], dat[owner]);
        end
      end
      checks++;
      if (m1_if.dat_r !== s_if.dat_r || m0_if.dat_r !== s_if.dat_r) begin
        failures++; $display("FAIL rand_rdata@%0d: got %h/%h expected %h", n, m0_if.dat_r, m1_if.dat_r, s_if.dat_r);
      end
      // What the arbiter should do at the coming clock edge.
      if (inerr || owner < 0) begin
        inerr = 0;
        waitc = 0;
        if (c[0] && c[1]) owner = 1 - last;
        else if (c[0]) owner = 0;
        else if (c[1]) owner = 1;
        else owner = -1;
      end else if (!c[owner]) begin
        last = owner;
        owner = c[1 - owner] ? 1 - owner : -1;
        waitc = 0;
      end else if (st[owner] && !sa && !se) begin
        if (waitc == TO - 1) begin
          inerr = 1; eowner = owner; last = owner; owner = -1; waitc = 0;
          if (mto < 65535) mto++;
        end else begin
          waitc++;
        end
      end else begin
        waitc = 0;
      end
    end
    exp_to = mto;
    settle();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive_m(0, 1'b1, 1'b1, 1'b1, 32'h300, 32'h1, 3'b010);
    @(negedge clk);
    s_if.ack = 1'b1;
    #1;
    checks++;
    if (obs() !== 8'b01_111000) begin failures++; $display("FAIL rmid_beat1: got %b expected %b", obs(), 8'b01_111000); end
    @(negedge clk);
    drive_m(0, 1'b1, 1'b1, 1'b1, 32'h304, 32'h2, 3'b010);
    rst = 1'b1;
    #1;
    checks++;
    if (obs() !== 8'b01_000000) begin failures++; $display("FAIL rmid_same_cycle: got %b expected %b", obs(), 8'b01_000000); end
    @(negedge clk);
    rst = 1'b0;
    s_if.ack = 1'b0;
    drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    exp_to = 0;
    #1;
    checks++;
    if (obs() !== 8'h00) begin failures++; $display("FAIL rmid_after: got %b expected %b", obs(), 8'h00); end
    checks++;
    if (tocnt !== 16'(exp_to)) begin failures++; $display("FAIL rmid_tocnt: got %0d expected %0d", tocnt, exp_to); end
    @(negedge clk);
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'h310, 32'h0, 3'b000);
    drive_m(1, 1'b1, 1'b1, 1'b0, 32'h410, 32'h0, 3'b000);
    @(negedge clk);
    #1;
    checks++;
    if (obs() !== 8'b01_110000) begin failures++; $display("FAIL rmid_tie: got %b expected %b", obs(), 8'b01_110000); end
    settle();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_tie();
    test_burst();
    test_watchdog();
    test_slave_err();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
